// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write master: FSM encoding and bit-phase constants.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam int              PH_W          = 2;
  localparam int              TICKS_PER_BIT = 4;
  localparam logic [PH_W-1:0] PH_LAST       = PH_W'(TICKS_PER_BIT - 1);
  localparam logic            W_BIT         = 1'b0;

endpackage

// File: rtl/sccb_byte_shifter.sv
// 8-bit parallel-load, MSB-first shift register with a down-counting bit index.
module sccb_byte_shifter
  import sccb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic [7:0] din_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic [2:0] bit_idx_o,
  output logic       last_o
);

  logic [7:0] sh_q;
  logic [2:0] idx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sh_q  <= din_i;
      idx_q <= 3'd7;
    end else if (shift_i) begin
      sh_q  <= {sh_q[6:0], 1'b0};
      idx_q <= idx_q - 3'd1;
    end
  end

  assign bit_o     = sh_q[7];
  assign bit_idx_o = idx_q;
  assign last_o    = (idx_q == 3'd0);

endmodule

// File: rtl/sccb_write_master.sv
// Tick-paced SCCB/I2C register write master (START, dev+W, reg, data, STOP), 4 ticks per SCL bit.
// Define SCCB_ACK_CHECK_EN to abort on NACK and report it on err_o; otherwise the ninth bit is ignored.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int NUM_BYTES = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] dev_addr_i,
  input  logic [7:0]        reg_addr_i,
  input  logic [7:0]        wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              scl_o,
  output logic              sda_oe_o,
  input  logic              sda_i
);

  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] dev_q;
  logic [7:0]        reg_q, wdata_q;
  logic              accept, load, shift, nack;
  logic [7:0]        load_dat;
  logic              tx_bit, last_bit;
  logic [2:0]        unused_bit_idx;

  sccb_byte_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (load),
    .din_i     (load_dat),
    .shift_i   (shift),
    .bit_o     (tx_bit),
    .bit_idx_o (unused_bit_idx),
    .last_o    (last_bit)
  );

  always_comb begin
    case (byte_d)
      2'd0:    load_dat = {dev_q, W_BIT};
      2'd1:    load_dat = reg_q;
      default: load_dat = wdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    byte_d   = byte_q;
    accept   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    scl_o    = 1'b1;
    sda_oe_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_START;
          ph_d    = '0;
        end
      end
      ST_START: begin
        scl_o    = (ph_q != PH_LAST);
        sda_oe_o = (ph_q != 2'd0);
        if (tick_i) begin
          ph_d = ph_q + PH_W'(1);
          if (ph_q == PH_LAST) begin
            state_d = ST_BYTE;
            byte_d  = 2'd0;
            load    = 1'b1;
          end
        end
      end
      ST_BYTE: begin
        scl_o    = (ph_q == 2'd1) || (ph_q == 2'd2);
        sda_oe_o = ~tx_bit;
        if (tick_i) begin
          ph_d = ph_q + PH_W'(1);
          if (ph_q == PH_LAST) begin
            if (last_bit) state_d = ST_ACK;
            else          shift   = 1'b1;
          end
        end
      end
      ST_ACK: begin
        scl_o = (ph_q == 2'd1) || (ph_q == 2'd2);
        if (tick_i) begin
          ph_d = ph_q + PH_W'(1);
          if (ph_q == PH_LAST) begin
            if (byte_q == LAST_BYTE || nack) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_BYTE;
              byte_d  = byte_q + 2'd1;
              load    = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        scl_o    = (ph_q != 2'd0);
        sda_oe_o = (ph_q != PH_LAST);
        if (tick_i) begin
          ph_d = ph_q + PH_W'(1);
          if (ph_q == PH_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      byte_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      byte_q  <= byte_d;
      if (accept) begin
        dev_q   <= dev_addr_i;
        reg_q   <= reg_addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o = (state_q == ST_DONE);

`ifdef SCCB_ACK_CHECK_EN
  logic nack_q, err_q;

  // NACK is only published on err_o when the transaction completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nack_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      nack_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_ACK && tick_i && ph_q == 2'd2 && sda_i) nack_q <= 1'b1;
      if (state_q == ST_STOP && state_d == ST_DONE) err_q <= nack_q;
    end
  end

  assign nack  = nack_q;
  assign err_o = err_q;
`else
  logic unused_sda;

  assign unused_sda = sda_i;
  assign nack       = 1'b0;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master with an SCCB slave model and bus protocol monitor.
module tb_sccb_write_master;

  localparam int TICK_DIV = 250;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_i = 1'b0;
  logic       start_i = 1'b0;
  logic [6:0] dev_addr_i = '0;
  logic [7:0] reg_addr_i = '0;
  logic [7:0] wdata_i = '0;
  logic       busy_o, done_o, err_o, scl_o, sda_oe_o;
  logic       slave_drive = 1'b0;
  wire        sda_line = !(sda_oe_o || slave_drive);

  int n_cmp = 0;
  int n_bad = 0;

  sccb_write_master dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick_i     (tick_i),
    .start_i    (start_i),
    .dev_addr_i (dev_addr_i),
    .reg_addr_i (reg_addr_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .scl_o      (scl_o),
    .sda_oe_o   (sda_oe_o),
    .sda_i      (sda_line)
  );

  always #5 clk = ~clk;

  int tdiv = 0;
  always @(negedge clk) begin
    if (tdiv == TICK_DIV - 1) begin
      tdiv   = 0;
      tick_i = 1'b1;
    end else begin
      tdiv++;
      tick_i = 1'b0;
    end
  end

  int tick_total = 0;
  always @(posedge clk) if (tick_i) tick_total <= tick_total + 1;

  // Slave model plus monitor: START/STOP detection, byte capture, ACK drive, SCL high-time check.
  bit         chk_en = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_frame = 1'b0;
  int         bitcnt = 0;
  int         k = 0;
  logic [7:0] shreg = '0;
  logic [7:0] rx_q[$];
  logic [2:0] nack_mask = '0;
  int         hi_trans = 0;
  int         hi_viol = 0;
  int         hcnt = 0;
  bit         rise_valid = 1'b0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (!chk_en) begin
      in_frame    = 1'b0;
      bitcnt      = 0;
      slave_drive = 1'b0;
      rise_valid  = 1'b0;
    end else if (scl_o && prev_scl && (sda_line != prev_sda)) begin
      hi_trans++;
      rise_valid = 1'b0;
      if (!sda_line) begin
        in_frame = 1'b1;
        bitcnt   = 0;
        rx_q.delete();
      end else begin
        in_frame    = 1'b0;
        slave_drive = 1'b0;
      end
    end else if (scl_o && !prev_scl) begin
      hcnt       = 1;
      rise_valid = 1'b1;
      if (in_frame && bitcnt < 8) shreg = {shreg[6:0], sda_line};
      if (in_frame) bitcnt++;
    end else if (scl_o) begin
      hcnt++;
    end else if (prev_scl) begin
      if (rise_valid && hcnt != 2 * TICK_DIV) hi_viol++;
      rise_valid = 1'b0;
      if (in_frame && bitcnt == 8) begin
        k = rx_q.size();
        rx_q.push_back(shreg);
        slave_drive = (k < 3) ? !nack_mask[k] : 1'b1;
      end else if (in_frame && bitcnt == 9) begin
        slave_drive = 1'b0;
        bitcnt      = 0;
      end
    end
    prev_scl = scl_o;
    prev_sda = sda_line;
  end

  task automatic do_accept(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                           output int t0);
    @(negedge clk);
    dev_addr_i = d;
    reg_addr_i = r;
    wdata_i    = w;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t0      = tick_total;
  endtask

  task automatic wait_ticks(input int t0, input int n);
    for (int i = 0; i < (n + 2) * TICK_DIV; i++) begin
      if (tick_total - t0 >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int t0, output bit ok, output int dt);
    ok = 1'b0;
    for (int i = 0; i < 140 * TICK_DIV; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    dt = tick_total - t0;
  endtask

  task automatic test_reset;
    bit seen = 1'b0;
    chk_en = 1'b0;
    rstn   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (scl_o !== 1'b1)    begin n_bad++; $display("FAIL rst_scl got=%b exp=1", scl_o); end
    n_cmp++; if (sda_oe_o !== 1'b0) begin n_bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe_o); end
    n_cmp++; if (busy_o !== 1'b0)   begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0)   begin n_bad++; $display("FAIL rst_done got=%b exp=0", done_o); end
    n_cmp++; if (err_o !== 1'b0)    begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    rstn = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      @(negedge clk);
      if (busy_o || !scl_o || sda_oe_o || done_o) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0)   begin n_bad++; $display("FAIL idle_bus_activity got=%b exp=0", seen); end
    n_cmp++; if (done_cnt !== 0)  begin n_bad++; $display("FAIL idle_done_cnt got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_reset_mid_byte;
    int t0;
    nack_mask = 3'b000;
    do_accept(7'h21, 8'h12, 8'h80, t0);
    wait_ticks(t0, 50);
    // 50 ticks in: byte 1 (0x12), bit 5 = 0, phase 2 -> SCL high, SDA pulled low.
    n_cmp++; if (scl_o !== 1'b1)    begin n_bad++; $display("FAIL mid_scl got=%b exp=1", scl_o); end
    n_cmp++; if (sda_oe_o !== 1'b1) begin n_bad++; $display("FAIL mid_sda_oe got=%b exp=1", sda_oe_o); end
    n_cmp++; if (busy_o !== 1'b1)   begin n_bad++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
    chk_en = 1'b0;
    rstn   = 1'b0;
    #1;
    n_cmp++; if (scl_o !== 1'b1)    begin n_bad++; $display("FAIL rstmid_scl got=%b exp=1", scl_o); end
    n_cmp++; if (sda_oe_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe_o); end
    n_cmp++; if (busy_o !== 1'b0)   begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_ack;
    int t0, dt, tr0, hv0, dc0;
    bit ok;
    logic [7:0] got;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h42; exp_b[1] = 8'h12; exp_b[2] = 8'h80;
    nack_mask = 3'b000;
    tr0 = hi_trans; hv0 = hi_viol; dc0 = done_cnt;
    do_accept(7'h21, 8'h12, 8'h80, t0);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL wr_busy_accept got=%b exp=1", busy_o); end
    wait_ticks(t0, 20);
    dev_addr_i = 7'h30;
    reg_addr_i = 8'hEE;
    wdata_i    = 8'h11;
    start_i    = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL wr_busy_restart got=%b exp=1", busy_o); end
    wait_done(t0, ok, dt);
    n_cmp++; if (ok !== 1'b1)     begin n_bad++; $display("FAIL wr_done_timeout got=%b exp=1", ok); end
    n_cmp++; if (dt !== 116)      begin n_bad++; $display("FAIL wr_latency got=%0d exp=116", dt); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL wr_busy_at_done got=%b exp=0", busy_o); end
    n_cmp++; if (err_o !== 1'b0)  begin n_bad++; $display("FAIL wr_err got=%b exp=0", err_o); end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt - dc0 !== 1) begin n_bad++; $display("FAIL wr_done_pulses got=%0d exp=1", done_cnt - dc0); end
    n_cmp++; if (rx_q.size() !== 3)    begin n_bad++; $display("FAIL wr_nbytes got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
      n_cmp++; if (got !== exp_b[i]) begin n_bad++; $display("FAIL wr_byte%0d got=%h exp=%h", i, got, exp_b[i]); end
    end
    n_cmp++; if (hi_trans - tr0 !== 2) begin n_bad++; $display("FAIL wr_sda_while_scl_hi got=%0d exp=2", hi_trans - tr0); end
    n_cmp++; if (hi_viol - hv0 !== 0)  begin n_bad++; $display("FAIL wr_scl_high_time got=%0d exp=0", hi_viol - hv0); end
    n_cmp++; if (scl_o !== 1'b1 || sda_oe_o !== 1'b0) begin n_bad++; $display("FAIL wr_bus_idle got=%b%b exp=10", scl_o, sda_oe_o); end
  endtask

  task automatic test_nack;
    int t0, dt, tr0, hv0, exp_dt, exp_n;
    bit ok;
    logic exp_err;
    logic [7:0] got;
`ifdef SCCB_ACK_CHECK_EN
    exp_dt = 44; exp_n = 1; exp_err = 1'b1;
`else
    exp_dt = 116; exp_n = 3; exp_err = 1'b0;
`endif
    nack_mask = 3'b001;
    tr0 = hi_trans; hv0 = hi_viol;
    do_accept(7'h3C, 8'h0A, 8'h55, t0);
    wait_done(t0, ok, dt);
    n_cmp++; if (ok !== 1'b1)     begin n_bad++; $display("FAIL nk_done_timeout got=%b exp=1", ok); end
    n_cmp++; if (dt !== exp_dt)   begin n_bad++; $display("FAIL nk_latency got=%0d exp=%0d", dt, exp_dt); end
    n_cmp++; if (err_o !== exp_err) begin n_bad++; $display("FAIL nk_err_at_done got=%b exp=%b", err_o, exp_err); end
    repeat (20) @(negedge clk);
    n_cmp++; if (err_o !== exp_err) begin n_bad++; $display("FAIL nk_err_held got=%b exp=%b", err_o, exp_err); end
    n_cmp++; if (rx_q.size() !== exp_n) begin n_bad++; $display("FAIL nk_nbytes got=%0d exp=%0d", rx_q.size(), exp_n); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    n_cmp++; if (got !== 8'h78)   begin n_bad++; $display("FAIL nk_byte0 got=%h exp=78", got); end
    n_cmp++; if (hi_trans - tr0 !== 2) begin n_bad++; $display("FAIL nk_sda_while_scl_hi got=%0d exp=2", hi_trans - tr0); end
    n_cmp++; if (hi_viol - hv0 !== 0)  begin n_bad++; $display("FAIL nk_scl_high_time got=%0d exp=0", hi_viol - hv0); end
`ifdef SCCB_ACK_CHECK_EN
    do_accept(7'h3C, 8'h0B, 8'h66, t0);
    n_cmp++; if (err_o !== 1'b0)  begin n_bad++; $display("FAIL nk_err_clear got=%b exp=0", err_o); end
    wait_done(t0, ok, dt);
    n_cmp++; if (dt !== 44 || ok !== 1'b1) begin n_bad++; $display("FAIL nk2_latency got=%0d ok=%b exp=44", dt, ok); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_byte();
    test_write_ack();
    test_nack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
